regbank_wb_arbiter: RTL and testbench
=====================================

Name: regbank_wb_arbiter

Overview:
- Shares the register bank's single write port between two writeback requesters: port A (ALU) and port B (load/memory).
- Each port feeds its own small FIFO. A round-robin arbiter drains the FIFO heads into a registered write-port driver that connects directly to the bank's write, wr and writereg inputs.
- Exports a pending-write mask so issue logic can stall reads of registers whose writes are still in flight.

Parameters:
- DW, 32, write data width.
- AW, 5, register index width; the bank has 2**AW registers.
- DEPTH, 2, entries per requester FIFO; power of two, minimum 2.
- DROP_R0, 1, when 1, writes to register 0 are consumed but never reach the bank.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- a_valid  in  1  port A write request.
- a_ready  out  1  port A FIFO not full.
- a_wr  in  AW  port A destination index.
- a_data  in  DW  port A write data.
- b_valid  in  1  port B write request.
- b_ready  out  1  port B FIFO not full.
- b_wr  in  AW  port B destination index.
- b_data  in  DW  port B write data.
- wb_write  out  1  bank write enable.
- wb_wr  out  AW  bank write index.
- wb_data  out  DW  bank write data.
- pend_mask  out  2**AW  bit i set = a write to register i is queued or on the write port.

Behaviour:
- Reset: clk is the clock; reset is synchronous, active-high.
  - FIFOs empty; wb_write=0, wb_wr=0, wb_data=0; pend_mask=0.
  - Round-robin pointer set so that A has priority on the first contention.
  - a_ready and b_ready are 0 during reset and 1 on the first cycle after it.
- Reset mid-operation: all queued and in-flight writes are discarded. No write is issued on the cycle after reset deasserts.
- Handshake:
  - A transfer occurs on a rising edge where valid and ready are both 1.
  - ready = FIFO not full; it does not depend on valid.
  - valid held while ready=0 loses no data.
  - wr and data are sampled only on a transfer.
- FIFO full and head pop in the same cycle: ready is computed from occupancy at the start of the cycle, so a full FIFO shows ready=0 even if its head is granted that cycle. No combinational ready-from-grant path.
- Arbitration (combinational, each cycle, over the FIFO heads):
  - Neither head valid: no grant.
  - One head valid: grant it.
  - Both heads valid: grant the port not granted last. The pointer updates only on a grant.
- Write-port register: on a grant, at the next edge:
  - wb_write = 1, except 0 when DROP_R0=1 and the head index is 0.
  - wb_wr and wb_data take the head's index and data.
  - The granted head pops.
  - With no grant, wb_write = 0. wb_wr and wb_data hold their last values.
- Throughput and latency:
  - One grant per cycle, so sustained output is 1 write/cycle.
  - Transfer on edge t: wb_write is high in the cycle following edge t+1, and the bank commits at edge t+2. Minimum latency is 2 edges from transfer to commit.
- Ordering:
  - Per-port order is preserved.
  - Same-index writes from A and B commit in grant order. Upstream is responsible for true write-after-write ordering across ports.
- pend_mask:
  - Registered; updated with the FIFO and write-port state.
  - OR over all valid FIFO entries and the write-port register (when wb_write=1) of a one-hot decode of their index.
  - Register-0 entries are excluded when DROP_R0=1.
- Simultaneous events:
  - Push and pop on the same FIFO in one cycle: occupancy unchanged, data order kept.
  - Push to an empty FIFO is not granted in the same cycle (no bypass).
- Pointer and count arithmetic:
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - The count is log2(DEPTH)+1 bits.

Decomposition:
- Shared package:
  - Constants for DW, AW, and number of registers (2**AW).
  - Typedef for a write request {wr, data}.
  - RR pointer encoding (PORT_A = 0, PORT_B = 1).
- One sub-module, wb_req_fifo:
  - Parameterised DEPTH-entry synchronous FIFO with push/pop/full/empty.
  - Exposes per-entry valid and index so the parent can build pend_mask.
  - Instantiated once per port.

Test Plan:
- Single write: after reset, a_valid=1, a_wr=3, a_data=0x1E for one transfer → wb_write=1 with wb_wr=3, wb_data=0x1E exactly one cycle, commit 2 edges after transfer. pend_mask bit 3 high while queued, 0 after commit.
- Contention: A (wr=5, data=50) and B (wr=6, data=60) transfer on the same edge → grants in order A then B on consecutive cycles. Repeat with B-first history → B then A.
- Backpressure: hold a_valid=1 with four distinct writes (wr 1..4, data 10..40) and no pops blocked → a_ready low when 2 entries are queued. All four commit in order with no loss or duplication.
- R0 drop: b_wr=0, b_data=0xFF → b_ready handshake completes, wb_write stays 0, pend_mask stays 0, and the next B write is issued normally.
- Reset mid-operation: queue 2 writes on A and 1 on B, assert reset for one cycle → no wb_write after reset, pend_mask=0, ready=1 on the next cycle.
- Full regression: 32 writes wr=i, data=i*10, alternating ports, then read back via the bank → every reg[i]=i*10, except reg[0]=0 with DROP_R0=1.

Source files
------------

// File: rtl/regbank_wb_arbiter_pkg.sv
// Shared constants and types for the register-bank writeback arbiter.
package regbank_wb_arbiter_pkg;

  localparam int RB_DW   = 32;
  localparam int RB_AW   = 5;
  localparam int RB_NREG = 1 << RB_AW;

  // One writeback request as it travels through a requester FIFO.
  typedef struct packed {
    logic [RB_AW-1:0] wr;
    logic [RB_DW-1:0] data;
  } wb_req_t;

  // Round-robin pointer encoding: which port was granted last.
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } rr_port_t;

endpackage

// File: rtl/regbank_wb_arbiter_wb_req_fifo.sv
// Small synchronous FIFO holding pending writeback requests for one port.
// Per-entry valid/index outputs let the parent build the pending-write mask.
module wb_req_fifo #(
  parameter int W     = 37,
  parameter int AW    = 5,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [W-1:0]  head,
  output logic [DEPTH-1:0] entry_valid,
  output logic [DEPTH-1:0] entry_is_head,
  output logic [AW-1:0] entry_wr [DEPTH]
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Entry g is live when its distance from the read pointer is below the occupancy.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [PW-1:0] off;
    assign off              = PW'(g) - rd_ptr;
    assign entry_valid[g]   = ({1'b0, off} < count);
    assign entry_is_head[g] = (PW'(g) == rd_ptr);
    assign entry_wr[g]      = mem[g][W-1 -: AW];
  end

  // Storage is written on push only; contents of dead entries are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally; simultaneous push and pop leave occupancy unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Shares the register bank write port between the ALU (A) and load (B)
// writeback paths: per-port FIFOs, round-robin arbitration over the heads,
// a registered write-port driver and a registered pending-write mask.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; ready reflects only "FIFO not full" (and is low in reset), never valid
// or the current grant; wr/data are sampled only on a transfer.
module regbank_wb_arbiter
  import regbank_wb_arbiter_pkg::*;
#(
  parameter int DW      = RB_DW,
  parameter int AW      = RB_AW,
  parameter int DEPTH   = 2,
  parameter int DROP_R0 = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic [AW-1:0]      a_wr,
  input  logic [DW-1:0]      a_data,
  input  logic               b_valid,
  output logic               b_ready,
  input  logic [AW-1:0]      b_wr,
  input  logic [DW-1:0]      b_data,
  output logic               wb_write,
  output logic [AW-1:0]      wb_wr,
  output logic [DW-1:0]      wb_data,
  output logic [(1<<AW)-1:0] pend_mask
);

  localparam int NREG = 1 << AW;
  localparam int W    = AW + DW;

  logic             a_full, a_empty, b_full, b_empty;
  logic             a_push, b_push, a_pop, b_pop;
  logic [W-1:0]     a_head, b_head, gnt_req;
  logic [DEPTH-1:0] a_ent_valid, a_ent_head, b_ent_valid, b_ent_head;
  logic [AW-1:0]    a_ent_wr [DEPTH];
  logic [AW-1:0]    b_ent_wr [DEPTH];
  logic             grant;
  rr_port_t         sel;
  rr_port_t         last_q;
  logic [AW-1:0]    gnt_wr;
  logic [DW-1:0]    gnt_data;
  logic             gnt_drop;
  logic [NREG-1:0]  pend_next;

  // Register-0 writes vanish at the bank when dropping is enabled.
  function automatic logic dropped(input logic [AW-1:0] idx);
    return (DROP_R0 != 0) && (idx == '0);
  endfunction

  assign a_ready = ~a_full & ~reset;
  assign b_ready = ~b_full & ~reset;
  assign a_push  = a_valid & a_ready;
  assign b_push  = b_valid & b_ready;

  wb_req_fifo #(.W(W), .AW(AW), .DEPTH(DEPTH)) u_fifo_a (
    .clk(clk), .reset(reset), .push(a_push), .push_data({a_wr, a_data}),
    .pop(a_pop), .full(a_full), .empty(a_empty), .head(a_head),
    .entry_valid(a_ent_valid), .entry_is_head(a_ent_head), .entry_wr(a_ent_wr)
  );

  wb_req_fifo #(.W(W), .AW(AW), .DEPTH(DEPTH)) u_fifo_b (
    .clk(clk), .reset(reset), .push(b_push), .push_data({b_wr, b_data}),
    .pop(b_pop), .full(b_full), .empty(b_empty), .head(b_head),
    .entry_valid(b_ent_valid), .entry_is_head(b_ent_head), .entry_wr(b_ent_wr)
  );

  // Round-robin choice over the FIFO heads; on contention the port not granted last wins.
  always_comb begin
    grant = 1'b0;
    sel   = PORT_A;
    if (!a_empty && !b_empty) begin
      grant = 1'b1;
      sel   = (last_q == PORT_A) ? PORT_B : PORT_A;
    end else if (!a_empty) begin
      grant = 1'b1;
      sel   = PORT_A;
    end else if (!b_empty) begin
      grant = 1'b1;
      sel   = PORT_B;
    end
  end

  assign a_pop    = grant && (sel == PORT_A);
  assign b_pop    = grant && (sel == PORT_B);
  assign gnt_req  = (sel == PORT_B) ? b_head : a_head;
  assign gnt_wr   = gnt_req[W-1 -: AW];
  assign gnt_data = gnt_req[DW-1:0];
  assign gnt_drop = dropped(gnt_wr);

  // Next pending set: surviving FIFO entries, this cycle's pushes and the write being granted.
  always_comb begin
    pend_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (a_ent_valid[i] && !(a_pop && a_ent_head[i]) && !dropped(a_ent_wr[i]))
        pend_next[a_ent_wr[i]] = 1'b1;
      if (b_ent_valid[i] && !(b_pop && b_ent_head[i]) && !dropped(b_ent_wr[i]))
        pend_next[b_ent_wr[i]] = 1'b1;
    end
    if (a_push && !dropped(a_wr)) pend_next[a_wr] = 1'b1;
    if (b_push && !dropped(b_wr)) pend_next[b_wr] = 1'b1;
    if (grant && !gnt_drop)       pend_next[gnt_wr] = 1'b1;
  end

  // Write-port register, round-robin pointer and pending mask advance together.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_write  <= 1'b0;
      wb_wr     <= '0;
      wb_data   <= '0;
      last_q    <= PORT_B;
      pend_mask <= '0;
    end else begin
      wb_write  <= grant && !gnt_drop;
      pend_mask <= pend_next;
      if (grant) begin
        wb_wr   <= gnt_wr;
        wb_data <= gnt_data;
        last_q  <= sel;
      end
    end
  end

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Directed and randomized bench for regbank_wb_arbiter with a queue-based
// reference model (per-port order, pending set, FIFO occupancy) and a bank array.
module tb_regbank_wb_arbiter;
  import regbank_wb_arbiter_pkg::*;

  localparam int DW    = RB_DW;
  localparam int AW    = RB_AW;
  localparam int NREG  = RB_NREG;
  localparam int DEPTH = 2;
  localparam int REQ_W = AW + DW;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            a_valid = 1'b0, b_valid = 1'b0;
  logic [AW-1:0]   a_wr = '0, b_wr = '0;
  logic [DW-1:0]   a_data = '0, b_data = '0;
  logic            a_ready, b_ready, wb_write;
  logic [AW-1:0]   wb_wr;
  logic [DW-1:0]   wb_data;
  logic [NREG-1:0] pend_mask;

  int checks = 0;
  int failures = 0;
  bit a_stall_seen = 1'b0;

  // Accepted-but-not-yet-written requests per port, in arrival order.
  logic [REQ_W-1:0] qa[$];
  logic [REQ_W-1:0] qb[$];
  logic [DW-1:0]    bank [NREG];

  regbank_wb_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .DROP_R0(1)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_wr(a_wr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_wr(b_wr), .b_data(b_data),
    .wb_write(wb_write), .wb_wr(wb_wr), .wb_data(wb_data), .pend_mask(pend_mask)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model helpers ----------------
  function automatic logic is_r0(input logic [REQ_W-1:0] e);
    wb_req_t r;
    r = e;
    return r.wr == '0;
  endfunction

  function automatic int first_live_a();
    for (int i = 0; i < qa.size(); i++) if (!is_r0(qa[i])) return i;
    return -1;
  endfunction

  function automatic int first_live_b();
    for (int i = 0; i < qb.size(); i++) if (!is_r0(qb[i])) return i;
    return -1;
  endfunction

  function automatic int r0_count_a();
    int n = 0;
    foreach (qa[i]) if (is_r0(qa[i])) n++;
    return n;
  endfunction

  function automatic int r0_count_b();
    int n = 0;
    foreach (qb[i]) if (is_r0(qb[i])) n++;
    return n;
  endfunction

  function automatic logic [NREG-1:0] model_mask();
    logic [NREG-1:0] m = '0;
    wb_req_t r;
    foreach (qa[i]) begin r = qa[i]; if (r.wr != '0) m[r.wr] = 1'b1; end
    foreach (qb[i]) begin r = qb[i]; if (r.wr != '0) m[r.wr] = 1'b1; end
    return m;
  endfunction

  // Record transfers as the handshake completes; reset discards everything.
  always @(posedge clk) begin
    if (reset) begin
      qa.delete();
      qb.delete();
    end else begin
      if (a_valid && a_ready) qa.push_back({a_wr, a_data});
      if (b_valid && b_ready) qb.push_back({b_wr, b_data});
    end
  end

  // The bank itself: commits on the edge following a write-port cycle.
  always @(posedge clk) begin
    if (wb_write === 1'b1) bank[wb_wr] <= wb_data;
  end

  // Scoreboard: pending set, per-port order, and ready versus occupancy.
  always @(negedge clk) begin
    int ia, ib;
    logic [REQ_W-1:0] obs_e;
    if (!reset) begin
      chk("pend_mask_model", pend_mask, model_mask());
      if (wb_write) begin
        obs_e = {wb_wr, wb_data};
        ia = first_live_a();
        ib = first_live_b();
        if (ia >= 0 && qa[ia] == obs_e) begin
          checks++;
          for (int k = 0; k <= ia; k++) void'(qa.pop_front());
        end else if (ib >= 0 && qb[ib] == obs_e) begin
          checks++;
          for (int k = 0; k <= ib; k++) void'(qb.pop_front());
        end else begin
          chk("wb_entry_order", obs_e, (ia >= 0) ? qa[ia] : ((ib >= 0) ? qb[ib] : '0));
        end
      end
      if (r0_count_a() == 0) chk("a_ready_vs_occupancy", a_ready, qa.size() < DEPTH);
      if (r0_count_b() == 0) chk("b_ready_vs_occupancy", b_ready, qb.size() < DEPTH);
    end
  end

  // ---------------- driver ----------------
  // Called just after a falling edge; returns just after the falling edge that follows the transfer.
  task automatic drive(input rr_port_t port, input logic [AW-1:0] wr, input logic [DW-1:0] d);
    int budget;
    budget = 100;
    if (port == PORT_A) begin a_valid = 1'b1; a_wr = wr; a_data = d; end
    else                begin b_valid = 1'b1; b_wr = wr; b_data = d; end
    while (((port == PORT_A) ? !a_ready : !b_ready) && budget > 0) begin
      if (port == PORT_A) a_stall_seen = 1'b1;
      step();
      budget--;
    end
    chk("drive_ready_timeout", 64'(budget == 0), 64'(0));
    step();
    if (port == PORT_A) a_valid = 1'b0;
    else                b_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 300;
    while ((first_live_a() >= 0 || first_live_b() >= 0) && budget > 0) begin
      step();
      budget--;
    end
    chk(tag, 64'(budget == 0), 64'(0));
    step();
    step();
  endtask

  task automatic rand_port(input rr_port_t port, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) step();
      drive(port, AW'($urandom_range(0, NREG - 1)), DW'($urandom));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < NREG; i++) bank[i] = '0;

    // Reset state
    step();
    step();
    chk("reset_a_ready", a_ready, 0);
    chk("reset_b_ready", b_ready, 0);
    chk("reset_wb_write", wb_write, 0);
    chk("reset_wb_wr", wb_wr, 0);
    chk("reset_wb_data", wb_data, 0);
    chk("reset_pend_mask", pend_mask, 0);
    reset = 1'b0;
    step();
    chk("post_reset_a_ready", a_ready, 1);
    chk("post_reset_b_ready", b_ready, 1);
    chk("post_reset_wb_write", wb_write, 0);

    // Single write: no bypass, one write-port cycle, commit two edges after transfer
    drive(PORT_A, 5'd3, 32'h1E);
    chk("single_no_bypass", wb_write, 0);
    chk("single_pend_queued", pend_mask, 64'h8);
    step();
    chk("single_wb_write", wb_write, 1);
    chk("single_wb_wr", wb_wr, 3);
    chk("single_wb_data", wb_data, 32'h1E);
    chk("single_pend_on_port", pend_mask, 64'h8);
    step();
    chk("single_wb_write_drop", wb_write, 0);
    chk("single_pend_clear", pend_mask, 0);
    chk("single_bank_commit", bank[3], 32'h1E);

    // Contention with A granted last: B wins first
    fork
      drive(PORT_A, 5'd5, 32'd50);
      drive(PORT_B, 5'd6, 32'd60);
    join
    step();
    chk("contend_bfirst_wr0", {wb_write, wb_wr}, {1'b1, 5'd6});
    chk("contend_bfirst_d0", wb_data, 60);
    step();
    chk("contend_bfirst_wr1", {wb_write, wb_wr}, {1'b1, 5'd5});
    chk("contend_bfirst_d1", wb_data, 50);
    step();

    // Register-0 drop on B, then a normal B write
    drive(PORT_B, 5'd0, 32'hFF);
    chk("r0_pend_empty", pend_mask, 0);
    step();
    chk("r0_no_write", wb_write, 0);
    chk("r0_pend_still_empty", pend_mask, 0);
    drive(PORT_B, 5'd7, 32'h77);
    step();
    chk("after_r0_wr", {wb_write, wb_wr}, {1'b1, 5'd7});
    chk("after_r0_data", wb_data, 32'h77);
    step();

    // Contention with B granted last: A wins first
    fork
      drive(PORT_A, 5'd5, 32'd50);
      drive(PORT_B, 5'd6, 32'd60);
    join
    step();
    chk("contend_afirst_wr0", {wb_write, wb_wr}, {1'b1, 5'd5});
    step();
    chk("contend_afirst_wr1", {wb_write, wb_wr}, {1'b1, 5'd6});
    step();

    // Backpressure: both ports stream so A's FIFO fills and ready drops
    a_stall_seen = 1'b0;
    fork
      for (int i = 1; i <= 4; i++) drive(PORT_A, AW'(i), DW'(i * 10));
      for (int i = 8; i <= 11; i++) drive(PORT_B, AW'(i), DW'(i * 10));
    join
    drain("backpressure_drain_timeout");
    chk("backpressure_a_stalled", a_stall_seen, 1);
    for (int i = 1; i <= 4; i++) chk($sformatf("backpressure_bank_%0d", i), bank[i], i * 10);

    // Reset mid-operation discards queued and in-flight writes
    fork
      begin drive(PORT_A, 5'd12, 32'd120); drive(PORT_A, 5'd13, 32'd130); end
      drive(PORT_B, 5'd14, 32'd140);
    join
    chk("midreset_pend13_before", pend_mask[13], 1);
    reset = 1'b1;
    step();
    chk("midreset_a_ready_low", a_ready, 0);
    chk("midreset_b_ready_low", b_ready, 0);
    reset = 1'b0;
    step();
    chk("midreset_no_write", wb_write, 0);
    chk("midreset_pend_clear", pend_mask, 0);
    chk("midreset_a_ready", a_ready, 1);
    chk("midreset_b_ready", b_ready, 1);
    step();
    chk("midreset_no_write_late", wb_write, 0);

    // Randomized traffic on both ports, checked by the scoreboard
    fork
      rand_port(PORT_A, 60);
      rand_port(PORT_B, 60);
    join
    drain("random_drain_timeout");

    // Full regression: wr=i, data=i*10 alternating ports, then read the bank
    for (int i = 0; i < NREG; i++) begin
      drive((i % 2 == 0) ? PORT_A : PORT_B, AW'(i), DW'(i * 10));
      repeat ($urandom_range(0, 1)) step();
    end
    drain("regression_drain_timeout");
    for (int i = 0; i < NREG; i++)
      chk($sformatf("bank_reg_%0d", i), bank[i], (i == 0) ? 0 : i * 10);
    chk("model_queues_empty", 64'(first_live_a() + first_live_b()), 64'(-2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
